add_sequencer: RTL and testbench

Control block that sequences the two-operand add datapath: A/B operand registers, 8-bit adder and 4-way output select. Accepts a Start request and captures Data_A/Data_B. Steps the output through zero, A, B and sum phases under an FSM with stall (Hold) support, then reports completion. Replaces the free-running 2-bit select counter with a handshaked, restartable scheduler.

---
 rtl/add_sequencer.sv | 148 ++++++++++++++
 tb/tb_add_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/add_sequencer.sv
// Sequencer for the two-operand add datapath: captures A/B on Start, then shows A, B and their sum.
// Optional build macro ADD_SEQ_ACC_EN adds a running 16-bit accumulator to the SUM phase.
module add_sequencer #(
    parameter int PHASE_CYCLES = 1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [7:0]  Data_A,
    input  logic [7:0]  Data_B,
    input  logic        Hold,
    output logic        Busy,
    output logic        Load,
    output logic [1:0]  Sel,
    output logic [15:0] Data_out,
    output logic        Out_valid,
    output logic        Done
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        SHOW_A   = 2'b01,
        SHOW_B   = 2'b10,
        SHOW_SUM = 2'b11
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(PHASE_CYCLES - 1);

    state_t      state_r;
    logic [7:0]  cnt_r;
    logic [7:0]  a_r;
    logic [7:0]  b_r;
    logic        busy_r;
    logic [1:0]  sel_r;
    logic [15:0] data_out_r;
    logic        out_valid_r;
    logic        done_r;
    logic [15:0] sum_s;
    logic        last_s;
`ifdef ADD_SEQ_ACC_EN
    logic [15:0] acc_r;
`endif

    // Sum of the captured operands (plus the running accumulator when enabled)
    always_comb begin
`ifdef ADD_SEQ_ACC_EN
        sum_s = acc_r + {8'h00, a_r} + {8'h00, b_r};
`else
        sum_s = {8'h00, a_r} + {8'h00, b_r};
`endif
        last_s = (cnt_r == LAST_CNT);
    end

    // Load is the only combinational output: it flags the accepting edge
    always_comb begin
        Load = (state_r == IDLE) && Start && !Reset;
    end

    // Phase FSM; all visible outputs are registered alongside the state
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r     <= IDLE;
            cnt_r       <= 8'd0;
            a_r         <= 8'd0;
            b_r         <= 8'd0;
            busy_r      <= 1'b0;
            sel_r       <= 2'b00;
            data_out_r  <= 16'h0000;
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
`ifdef ADD_SEQ_ACC_EN
            acc_r       <= 16'h0000;
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (Start) begin
                        a_r         <= Data_A;
                        b_r         <= Data_B;
                        cnt_r       <= 8'd0;
                        state_r     <= SHOW_A;
                        busy_r      <= 1'b1;
                        sel_r       <= 2'b01;
                        data_out_r  <= {8'h00, Data_A};
                        out_valid_r <= 1'b1;
                    end else begin
                        busy_r      <= 1'b0;
                        sel_r       <= 2'b00;
                        data_out_r  <= 16'h0000;
                        out_valid_r <= 1'b0;
                    end
                end
                SHOW_A: begin
                    if (!Hold && last_s) begin
                        cnt_r      <= 8'd0;
                        state_r    <= SHOW_B;
                        sel_r      <= 2'b10;
                        data_out_r <= {8'h00, b_r};
                    end else if (!Hold) begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                SHOW_B: begin
                    if (!Hold && last_s) begin
                        cnt_r      <= 8'd0;
                        state_r    <= SHOW_SUM;
                        sel_r      <= 2'b11;
                        data_out_r <= sum_s;
                    end else if (!Hold) begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                SHOW_SUM: begin
                    if (!Hold && last_s) begin
                        cnt_r       <= 8'd0;
                        state_r     <= IDLE;
                        busy_r      <= 1'b0;
                        sel_r       <= 2'b00;
                        data_out_r  <= 16'h0000;
                        out_valid_r <= 1'b0;
                        done_r      <= 1'b1;
`ifdef ADD_SEQ_ACC_EN
                        acc_r       <= sum_s;
`endif
                    end else if (!Hold) begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= 8'd0;
                    busy_r      <= 1'b0;
                    sel_r       <= 2'b00;
                    data_out_r  <= 16'h0000;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign Busy      = busy_r;
    assign Sel       = sel_r;
    assign Data_out  = data_out_r;
    assign Out_valid = out_valid_r;
    assign Done      = done_r;

endmodule

// File: tb/tb_add_sequencer.sv
// Randomized self-checking bench for add_sequencer, with a cycle-level reference schedule per transaction.
`timescale 1ns/1ps
module tb_add_sequencer;

    localparam int P = 2;

    logic        Clock = 1'b0;
    logic        Reset, Start, Hold;
    logic [7:0]  Data_A, Data_B;
    logic        Busy, Load, Out_valid, Done;
    logic [1:0]  Sel;
    logic [15:0] Data_out;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic        expect_done;
    logic [15:0] model_acc;

    always #5 Clock = ~Clock;

    add_sequencer #(.PHASE_CYCLES(P)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Data_A(Data_A), .Data_B(Data_B),
        .Hold(Hold), .Busy(Busy), .Load(Load), .Sel(Sel), .Data_out(Data_out),
        .Out_valid(Out_valid), .Done(Done)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            Reset  = 1'b0;
            Start  = 1'b0;
            Hold   = 1'($urandom_range(1, 0));
            Data_A = 8'($urandom);
            Data_B = 8'($urandom);
            @(negedge Clock);
            check_eq("idle_busy", {15'd0, Busy}, 16'd0);
            check_eq("idle_sel", {14'd0, Sel}, 16'd0);
            check_eq("idle_data", Data_out, 16'h0000);
            check_eq("idle_valid", {15'd0, Out_valid}, 16'd0);
            check_eq("idle_done", {15'd0, Done}, {15'd0, expect_done});
            check_eq("idle_load", {15'd0, Load}, 16'd0);
            expect_done = 1'b0;
            step();
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            Reset  = 1'b1;
            Start  = 1'b1;
            Hold   = 1'($urandom_range(1, 0));
            Data_A = 8'($urandom);
            Data_B = 8'($urandom);
            @(negedge Clock);
            check_eq("reset_load", {15'd0, Load}, 16'd0);
            step();
        end
        Reset       = 1'b0;
        Start       = 1'b0;
        expect_done = 1'b0;
        model_acc   = 16'h0000;
    endtask

    // One transaction: accept, then walk the A/B/SUM schedule, with optional noise, forced hold or abort
    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input int hold_pct,
                           input bit noise, input bit abort_sum, input bit hold_b3);
        logic [15:0] exp_sum, exp_val;
        int phase, cnt, forced;
        Reset  = 1'b0;
        Start  = 1'b1;
        Data_A = a;
        Data_B = b;
        Hold   = 1'($urandom_range(1, 0));
        @(negedge Clock);
        check_eq("accept_load", {15'd0, Load}, 16'd1);
        check_eq("accept_busy", {15'd0, Busy}, 16'd0);
        check_eq("accept_sel", {14'd0, Sel}, 16'd0);
        check_eq("accept_done", {15'd0, Done}, {15'd0, expect_done});
        expect_done = 1'b0;
        step();
`ifdef ADD_SEQ_ACC_EN
        exp_sum = model_acc + {8'h00, a} + {8'h00, b};
`else
        exp_sum = {8'h00, a} + {8'h00, b};
`endif
        phase  = 1;
        cnt    = 0;
        forced = 0;
        while (phase < 4) begin
            Hold = ($urandom_range(99, 0) < hold_pct);
            if (hold_b3 && phase == 2 && cnt == P / 2 && forced < 3) begin
                Hold = 1'b1;
                forced++;
            end
            Start  = noise ? 1'($urandom_range(1, 0)) : 1'b0;
            Data_A = 8'($urandom);
            Data_B = 8'($urandom);
            Reset  = abort_sum && phase == 3;
            exp_val = (phase == 1) ? {8'h00, a} : (phase == 2) ? {8'h00, b} : exp_sum;
            @(negedge Clock);
            check_eq("phase_sel", {14'd0, Sel}, 16'(phase));
            check_eq("phase_data", Data_out, exp_val);
            check_eq("phase_valid", {15'd0, Out_valid}, 16'd1);
            check_eq("phase_busy", {15'd0, Busy}, 16'd1);
            check_eq("phase_done", {15'd0, Done}, 16'd0);
            check_eq("phase_load", {15'd0, Load}, 16'd0);
            step();
            if (Reset) begin
                Reset     = 1'b0;
                Start     = 1'b0;
                model_acc = 16'h0000;
                return;
            end
            if (!Hold) cnt++;
            if (cnt == P) begin
                phase++;
                cnt = 0;
            end
        end
        Start       = 1'b0;
        Hold        = 1'b0;
        expect_done = 1'b1;
        model_acc   = exp_sum;
    endtask

    initial begin
        Reset       = 1'b0;
        Start       = 1'b0;
        Hold        = 1'b0;
        Data_A      = 8'h00;
        Data_B      = 8'h00;
        expect_done = 1'b0;
        model_acc   = 16'h0000;

        do_reset(2);
        idle(2);

        run_txn(8'h12, 8'h34, 0, 1'b0, 1'b0, 1'b0);
        idle(2);

        run_txn(8'hFF, 8'hFF, 0, 1'b0, 1'b0, 1'b1);
        idle(1);

        // Start pulses while busy, then a back-to-back accept in the Done cycle
        run_txn(8'h21, 8'h43, 0, 1'b1, 1'b0, 1'b0);
        run_txn(8'h05, 8'h06, 0, 1'b0, 1'b0, 1'b0);
        idle(1);

        run_txn(8'h77, 8'h88, 0, 1'b0, 1'b1, 1'b0);
        idle(2);
        run_txn(8'h12, 8'h34, 0, 1'b0, 1'b0, 1'b0);
        idle(1);

        run_txn(8'h10, 8'h20, 0, 1'b0, 1'b0, 1'b0);
        run_txn(8'h01, 8'h02, 0, 1'b0, 1'b0, 1'b0);
        idle(1);
        do_reset(1);
        run_txn(8'h01, 8'h02, 0, 1'b0, 1'b0, 1'b0);
        idle(1);

        for (int t = 0; t < 30; t++) begin
            run_txn(8'($urandom), 8'($urandom), $urandom_range(40, 0),
                    1'($urandom_range(1, 0)), ($urandom_range(9, 0) == 0), 1'b0);
            idle($urandom_range(2, 0));
        end
        idle(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
